avmm_sram_responder: RTL and testbench
======================================

// Module: avmm_sram_responder
// PURPOSE
//  Avalon-MM slave memory model/responder: the far end of the dot-product engines' master ports.
//  Serves 32-bit word reads and writes from one master.
//  Fixed pipelined read latency, configurable waitrequest stall injection and an outstanding-read limit.
//  Used as the SRAM/SDRAM bank behind master_*/master2_* in simulation, and as an on-chip activation bank in synthesis.
// PARAMETERS
//  DEPTH         1024  number of 32-bit words; legal byte addresses 0 .. DEPTH*4-1
//  READ_LATENCY  2     cycles from read-accept edge to readdatavalid; legal range 1..8
//  WAIT_CYCLES   0     waitrequest cycles inserted before every command is accepted; 0 = accept at once
//  MAX_PEND      2     maximum reads in flight; legal range 1..READ_LATENCY
//  OOB_DATA      32'hDEAD_BEEF  readdata returned for out-of-range reads
// PORTS
//  clk                  in   1   clock; all logic on posedge
//  rst                  in   1   synchronous, active-high reset
//  slave_address        in   32  byte address; bits [1:0] are ignored
//  slave_read           in   1   read command; held until accepted
//  slave_write          in   1   write command; held until accepted
//  slave_writedata      in   32  write data
//  slave_waitrequest    out  1   1 = command not accepted this cycle
//  slave_readdata       out  32  read data; meaningful only while readdatavalid=1
//  slave_readdatavalid  out  1   one-cycle pulse per accepted read, in acceptance order
//  pend_count           out  4   reads currently in flight (debug)
//  err_oob              out  1   sticky: out-of-range access seen
//  err_proto            out  1   sticky: read and write asserted together
// BEHAVIOUR
//  Reset state: all outputs in a defined state.
//   - waitrequest=1, readdatavalid=0, readdata=0, pend_count=0, err_*=0.
//   - FSM in IDLE; stall counter cleared; read pipeline flushed.
//   - Memory contents are NOT reset and are retained across reset.
//   - Reset asserted mid-operation discards every in-flight read; no readdatavalid follows it.
//  Handshake and acceptance:
//   - cmd = slave_read | slave_write. A command is accepted in a cycle where cmd=1 and waitrequest=0.
//   - waitrequest is combinational: waitrequest = ~accept. It is 1 whenever no command is present.
//   - Credit: a read may be accepted only if (pend_count - pop) < MAX_PEND, where pop = readdatavalid this cycle.
//   - Writes need no credit.
//  FSM:
//   - IDLE: if cmd and WAIT_CYCLES==0 and credit is OK -> accept and stay in IDLE.
//     If cmd and WAIT_CYCLES>0 -> go to STALL with wcnt=1.
//   - STALL: waitrequest=1 while wcnt<WAIT_CYCLES; wcnt increments each cycle.
//     When wcnt==WAIT_CYCLES and credit is OK -> accept and go to IDLE; if credit is not OK, hold in STALL.
//     If cmd drops during STALL -> go to IDLE and clear wcnt (the command is abandoned, no side effects).
//  Write: on the accept edge, mem[address[ADDR_W+1:2]] <= writedata.
//   - A read accepted on the next cycle returns the new value.
//  Read: on the accept edge, mem[word] (or OOB_DATA) is captured into stage 0 of a READ_LATENCY-deep valid/data shift pipe.
//   - For a read accepted at edge k, readdatavalid=1 and readdata are valid in the cycle after edge k+READ_LATENCY-1.
//     In other words, they are sampled by the master at edge k+READ_LATENCY.
//   - Back-to-back accepts produce back-to-back responses.
//  Counting: pend_count += read_accept, -= pop, applied in the same cycle, so a simultaneous accept and pop nets to 0.
//   - pend_count never exceeds MAX_PEND.
//  Out of range: address >= DEPTH*4 raises err_oob.
//   - Such a read returns OOB_DATA with the normal latency.
//   - Such a write is dropped.
//  Simultaneous read+write: only the write is performed (one accept), no readdatavalid is produced, and err_proto is set.
//  Error flags: err_oob and err_proto clear only on rst.
//  Width: ADDR_W = $clog2(DEPTH). Upper address bits beyond the word index are compared only for the OOB check.
// TESTING
//  T1 (L=2,W=0): write 0x10<=0x0001_8000 accepted at edge 0; read 0x10 accepted at edge 1 -> readdatavalid at edge 3, readdata 0x0001_8000.
//  T2 (L=3,MAX_PEND=2,W=0): read 0x0,0x4,0x8 held every cycle -> accepts at edges 0,1,3; data valid at edges 3,4,6, in order; pend_count peaks at 2.
//  T3 (W=2): read held -> waitrequest=1 for 2 cycles, then 0 (accepted at the third edge); repeat with read dropped after 1 cycle -> FSM in IDLE, no readdatavalid.
//  T4: read 4*DEPTH -> readdata 0xDEAD_BEEF with normal latency, err_oob=1; write 4*DEPTH then read 0x0 -> mem[0] unchanged.
//  T5: read=write=1, addr 0x20, data 0x55 -> one accept, mem[8]=0x55, no readdatavalid, err_proto=1 until rst.
//  T6 (L=4): 3 reads in flight, rst for 1 cycle -> readdatavalid stays 0 afterwards, pend_count=0, err flags=0; memory data is intact on the next read.

Source files
------------

// File: rtl/avmm_sram_responder.sv
// Avalon-MM 32-bit word SRAM responder serving a single master (memory model / on-chip bank).
// Latency: reads return READ_LATENCY cycles after the accept edge; writes land on the accept edge.
// Backpressure: waitrequest stalls each command WAIT_CYCLES cycles and holds reads while MAX_PEND are in flight.
module avmm_sram_responder #(
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_CYCLES  = 0,
  parameter int          MAX_PEND     = 2,
  parameter logic [31:0] OOB_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic [3:0]  pend_count,
  output logic        err_oob,
  output logic        err_proto
);

  localparam int          ADDR_W     = $clog2(DEPTH);
  localparam int          WC_W       = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  // First illegal byte address; one extra bit so large DEPTH values cannot wrap.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]              state;
  logic [WC_W-1:0]         wcnt;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];
  logic [31:0]             mem      [DEPTH];

  logic              cmd;
  logic              is_rd;
  logic              pop;
  logic              credit_ok;
  logic              ready;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic              oob;
  logic [ADDR_W-1:0] word;
  logic [31:0]       rd_data;

  // Command decode, read credit and the combinational accept decision.
  always_comb begin
    cmd       = slave_read | slave_write;
    // A read that arrives together with a write is suppressed; only the write is performed.
    is_rd     = slave_read & ~slave_write;
    pop       = vld_pipe[READ_LATENCY-1];
    // The slot freed by a response leaving this cycle can be reused by a read accepted this cycle.
    credit_ok = ~is_rd | ((pend_count - 4'(pop)) < 4'(MAX_PEND));
    if (WAIT_CYCLES == 0) begin
      ready = (state == S_IDLE);
    end else begin
      ready = (state == S_STALL) && (wcnt == WC_W'(WAIT_CYCLES));
    end
    accept    = ~rst & cmd & credit_ok & ready;
    oob       = ({1'b0, slave_address} >= BYTE_LIMIT);
    word      = slave_address[ADDR_W+1:2];
    rd_accept = accept & is_rd;
    wr_accept = accept & slave_write & ~oob;
    rd_data   = oob ? OOB_DATA : mem[word];
  end

  assign slave_waitrequest   = ~accept;
  assign slave_readdatavalid = vld_pipe[READ_LATENCY-1];
  assign slave_readdata      = dat_pipe[READ_LATENCY-1];

  // Stall FSM: count WAIT_CYCLES before each accept; a dropped command is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else if (state == S_IDLE) begin
      if (cmd && (WAIT_CYCLES != 0)) begin
        state <= S_STALL;
        wcnt  <= WC_W'(1);
      end
    end else begin
      if (!cmd || accept) begin
        state <= S_IDLE;
        wcnt  <= '0;
      end else if (wcnt != WC_W'(WAIT_CYCLES)) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Read response pipe: stage 0 captures on accept, the last stage drives the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_accept;
      if (rd_accept) begin
        dat_pipe[0] <= rd_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word] <= slave_writedata;
    end
  end

  // Outstanding-read count: accept and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_count <= '0;
    end else begin
      pend_count <= pend_count + 4'(rd_accept) - 4'(pop);
    end
  end

  // Sticky error flags, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      err_oob   <= err_oob   | (accept & oob);
      err_proto <= err_proto | (accept & slave_read & slave_write);
    end
  end

endmodule

// File: tb/tb_avmm_sram_responder.sv
// Directed bench for avmm_sram_responder using four instances with different parameter sets.
// Inst 0: L=2,W=0,MAX=2   Inst 1: L=3,W=0,MAX=2   Inst 2: L=4,W=0,MAX=4   Inst 3: L=2,W=2,MAX=2
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_avmm_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd   [4];
  logic        wr   [4];
  logic [31:0] addr [4];
  logic [31:0] wdat [4];

  wire         wreq   [4];
  wire  [31:0] rdata  [4];
  wire         rvld   [4];
  wire  [3:0]  pend   [4];
  wire         eoob   [4];
  wire         eproto [4];

  int n_chk  = 0;
  int n_fail = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      avmm_sram_responder #(
        .DEPTH        (1024),
        .READ_LATENCY ((g == 1) ? 3 : ((g == 2) ? 4 : 2)),
        .WAIT_CYCLES  ((g == 3) ? 2 : 0),
        .MAX_PEND     ((g == 2) ? 4 : 2),
        .OOB_DATA     (32'hDEAD_BEEF)
      ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .slave_address       (addr[g]),
        .slave_read          (rd[g]),
        .slave_write         (wr[g]),
        .slave_writedata     (wdat[g]),
        .slave_waitrequest   (wreq[g]),
        .slave_readdata      (rdata[g]),
        .slave_readdatavalid (rvld[g]),
        .pend_count          (pend[g]),
        .err_oob             (eoob[g]),
        .err_proto           (eproto[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current command until accepted (bounded); returns just after the accept edge.
  task automatic wait_accept(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!wreq[i]) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  // Wait for the response of a read accepted at the previous edge; lat counts edges from accept.
  task automatic get_resp(input int i, output logic [31:0] d, output int lat);
    lat = 99;
    d   = 'x;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (rvld[i]) begin
        lat = n;
        d   = rdata[i];
        break;
      end
    end
    tick();
  endtask

  task automatic wr_word(input int i, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    wr[i]   = 1'b1;
    addr[i] = a;
    wdat[i] = d;
    wait_accept(i, ok);
    wr[i]   = 1'b0;
    check($sformatf("wr_accept%0d", i), 32'(ok), 32'd1);
  endtask

  task automatic rd_word(input int i, input logic [31:0] a, output logic [31:0] d, output int lat);
    bit ok;
    rd[i]   = 1'b1;
    addr[i] = a;
    wait_accept(i, ok);
    rd[i]   = 1'b0;
    check($sformatf("rd_accept%0d", i), 32'(ok), 32'd1);
    get_resp(i, d, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          lat;
    int          nv;
    int          nw;
    int          na;
    int          pmax;
    int          acc_e [4];
    int          vld_e [4];
    logic [31:0] vdat  [4];

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd[i]   = 1'b0;
      wr[i]   = 1'b0;
      addr[i] = '0;
      wdat[i] = '0;
    end
    repeat (2) tick();

    // Reset state of every instance
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_wreq%0d", i),   32'(wreq[i]),   32'd1);
      check($sformatf("rst_vld%0d", i),    32'(rvld[i]),   32'd0);
      check($sformatf("rst_data%0d", i),   rdata[i],       32'd0);
      check($sformatf("rst_pend%0d", i),   32'(pend[i]),   32'd0);
      check($sformatf("rst_oob%0d", i),    32'(eoob[i]),   32'd0);
      check($sformatf("rst_proto%0d", i),  32'(eproto[i]), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    // T1: write then read the same word, response sampled at edge 3
    wr[0] = 1'b1; addr[0] = 32'h10; wdat[0] = 32'h0001_8000;
    @(negedge clk); check("t1_wr_wreq", 32'(wreq[0]), 32'd0);
    tick();
    wr[0] = 1'b0; rd[0] = 1'b1;
    @(negedge clk); check("t1_rd_wreq", 32'(wreq[0]), 32'd0);
    tick();
    rd[0] = 1'b0;
    @(negedge clk); check("t1_vld_e2", 32'(rvld[0]), 32'd0);
    tick();
    @(negedge clk); check("t1_vld_e3", 32'(rvld[0]), 32'd1);
    check("t1_data", rdata[0], 32'h0001_8000);
    tick();
    @(negedge clk); check("t1_vld_e4", 32'(rvld[0]), 32'd0);
    tick();

    // T4: out-of-range read returns OOB_DATA; out-of-range write is dropped
    wr_word(0, 32'h0, 32'hA5A5_0000);
    rd_word(0, 32'd4096, d, lat);
    check("t4_oob_data", d, 32'hDEAD_BEEF);
    check("t4_oob_lat", 32'(lat), 32'd2);
    check("t4_err_oob", 32'(eoob[0]), 32'd1);
    wr_word(0, 32'd4096, 32'h1234_5678);
    rd_word(0, 32'h0, d, lat);
    check("t4_mem0_kept", d, 32'hA5A5_0000);
    check("t4_no_proto", 32'(eproto[0]), 32'd0);

    // T5: read and write together -> write only, no response, err_proto
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'h55;
    @(negedge clk); check("t5_wreq", 32'(wreq[0]), 32'd0);
    tick();
    rd[0] = 1'b0; wr[0] = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvld[0]) nv++;
    end
    tick();
    check("t5_no_rvld", 32'(nv), 32'd0);
    check("t5_err_proto", 32'(eproto[0]), 32'd1);
    rd_word(0, 32'h20, d, lat);
    check("t5_mem8", d, 32'h55);
    check("t5_proto_sticky", 32'(eproto[0]), 32'd1);

    // T2: L=3, MAX_PEND=2, reads held every cycle -> accepts at 0,1,3; data at 3,4,6
    wr_word(1, 32'h0, 32'h0000_0100);
    wr_word(1, 32'h4, 32'h0000_0104);
    wr_word(1, 32'h8, 32'h0000_0108);
    na = 0; nv = 0; pmax = 0;
    for (int i = 0; i < 4; i++) begin
      acc_e[i] = -1; vld_e[i] = -1; vdat[i] = '0;
    end
    rd[1] = 1'b1; addr[1] = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd[1] && !wreq[1] && na < 4) begin acc_e[na] = c; na++; end
      if (rvld[1] && nv < 4) begin vld_e[nv] = c; vdat[nv] = rdata[1]; nv++; end
      if (int'(pend[1]) > pmax) pmax = int'(pend[1]);
      tick();
      if (na >= 3) rd[1] = 1'b0;
      else addr[1] = 32'(na * 4);
    end
    check("t2_n_acc", 32'(na), 32'd3);
    check("t2_acc0", 32'(acc_e[0]), 32'd0);
    check("t2_acc1", 32'(acc_e[1]), 32'd1);
    check("t2_acc2", 32'(acc_e[2]), 32'd3);
    check("t2_n_vld", 32'(nv), 32'd3);
    check("t2_vld0", 32'(vld_e[0]), 32'd3);
    check("t2_vld1", 32'(vld_e[1]), 32'd4);
    check("t2_vld2", 32'(vld_e[2]), 32'd6);
    check("t2_dat0", vdat[0], 32'h0000_0100);
    check("t2_dat1", vdat[1], 32'h0000_0104);
    check("t2_dat2", vdat[2], 32'h0000_0108);
    check("t2_pend_peak", 32'(pmax), 32'd2);

    // T3: WAIT_CYCLES=2 -> two stall cycles, accept on the third edge
    wr_word(3, 32'h0, 32'h3333_0000);
    rd[3] = 1'b1; addr[3] = 32'h0;
    @(negedge clk); check("t3_w0", 32'(wreq[3]), 32'd1);
    tick();
    @(negedge clk); check("t3_w1", 32'(wreq[3]), 32'd1);
    tick();
    @(negedge clk); check("t3_w2", 32'(wreq[3]), 32'd0);
    tick();
    rd[3] = 1'b0;
    get_resp(3, d, lat);
    check("t3_lat", 32'(lat), 32'd2);
    check("t3_data", d, 32'h3333_0000);
    // Abandoned command: read dropped after one stall cycle
    rd[3] = 1'b1;
    @(negedge clk); check("t3_ab_w0", 32'(wreq[3]), 32'd1);
    tick();
    rd[3] = 1'b0;
    nv = 0; nw = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvld[3]) nv++;
      if (!wreq[3]) nw++;
    end
    tick();
    check("t3_ab_no_rvld", 32'(nv), 32'd0);
    check("t3_ab_no_acc", 32'(nw), 32'd0);
    // FSM back in IDLE: a fresh read sees the full stall again
    rd[3] = 1'b1;
    @(negedge clk); check("t3_re_w0", 32'(wreq[3]), 32'd1);
    tick();
    @(negedge clk); check("t3_re_w1", 32'(wreq[3]), 32'd1);
    tick();
    @(negedge clk); check("t3_re_w2", 32'(wreq[3]), 32'd0);
    tick();
    rd[3] = 1'b0;
    get_resp(3, d, lat);
    check("t3_re_data", d, 32'h3333_0000);

    // T6: L=4, three reads in flight, then a one-cycle reset
    wr_word(2, 32'h0, 32'h0000_6000);
    wr_word(2, 32'h4, 32'h0000_6004);
    wr_word(2, 32'h8, 32'h0000_6008);
    rd[2] = 1'b1; addr[2] = 32'h0;
    @(negedge clk); check("t6_acc0", 32'(wreq[2]), 32'd0);
    tick();
    addr[2] = 32'h4;
    @(negedge clk); check("t6_acc1", 32'(wreq[2]), 32'd0);
    tick();
    addr[2] = 32'h8;
    @(negedge clk); check("t6_acc2", 32'(wreq[2]), 32'd0);
    tick();
    rd[2] = 1'b0;
    @(negedge clk); check("t6_pend3", 32'(pend[2]), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvld[2]) nv++;
    end
    check("t6_no_rvld", 32'(nv), 32'd0);
    check("t6_pend0", 32'(pend[2]), 32'd0);
    check("t6_rdata0", rdata[2], 32'd0);
    check("t6_oob_clr", 32'(eoob[0]), 32'd0);
    check("t6_proto_clr", 32'(eproto[0]), 32'd0);
    tick();
    rd_word(2, 32'h4, d, lat);
    check("t6_mem_kept", d, 32'h0000_6004);
    check("t6_lat", 32'(lat), 32'd4);
    rd_word(0, 32'h10, d, lat);
    check("t6_mem_kept_u0", d, 32'h0001_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
